// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Parametrised up/down modulo counter for timers and event counting.
//   The count range is 0..MAX. A prescaler turns every PRESCALE enabled
//   cycles into one count step. At a limit the counter either wraps, which
//   pulses tc for one cycle, or holds and raises sat. All outputs are
//   registered.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MAX      : top count value (1..2**WIDTH-1)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
//   PRESCALE : enabled cycles per count step (1..256)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous reset, active low
//   en       in   count enable; gates both the prescaler and stepping
//   up       in   direction (1 = up, 0 = down), sampled on the step edge
//   clr      in   synchronous clear (highest priority)
//   load     in   synchronous load of load_val, clamped to MAX
//   load_val in   value to load [WIDTH]
//   cout     out  current count [WIDTH]
//   tc       out  one-cycle pulse on a wrap step
//   sat      out  high while a step is blocked at a limit (SATURATE=1 only)
module updown_mod_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cout,
  output logic             tc,
  output logic             sat
);

  // The prescaler keeps at least one bit, so PRESCALE=1 still elaborates.
  // Its top value is then 0, which makes every enabled cycle a step.
  localparam int               PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] L_PRE_TOP = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] L_MAX     = WIDTH'(MAX);
  localparam bit               L_SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] r_cout;
  logic [PRE_W-1:0] r_pre;
  logic             r_tc;
  logic             r_sat;

  logic             w_pre_done;
  logic             w_at_limit;
  logic [WIDTH-1:0] w_stepped;
  logic [WIDTH-1:0] w_wrap_val;
  logic [WIDTH-1:0] w_load_clamped;

  always_comb begin
    w_pre_done     = (r_pre == L_PRE_TOP);
    w_at_limit     = up ? (r_cout == L_MAX) : (r_cout == '0);
    w_stepped      = up ? (r_cout + WIDTH'(1)) : (r_cout - WIDTH'(1));
    w_wrap_val     = up ? '0 : L_MAX;
    w_load_clamped = (load_val > L_MAX) ? L_MAX : load_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cout <= '0;
      r_pre  <= '0;
      r_tc   <= 1'b0;
      r_sat  <= 1'b0;
    end else if (clr) begin
      r_cout <= '0;
      r_pre  <= '0;
      r_tc   <= 1'b0;
      r_sat  <= 1'b0;
    end else if (load) begin
      r_cout <= w_load_clamped;
      r_pre  <= '0;
      r_tc   <= 1'b0;
      r_sat  <= 1'b0;
    end else if (en) begin
      if (w_pre_done) begin
        r_pre <= '0;
        if (!w_at_limit) begin
          r_cout <= w_stepped;
          r_tc   <= 1'b0;
          r_sat  <= 1'b0;
        end else if (L_SAT) begin
          // Blocked step: the count holds, and sat stays up until the count moves.
          r_tc  <= 1'b0;
          r_sat <= 1'b1;
        end else begin
          r_cout <= w_wrap_val;
          r_tc   <= 1'b1;
          r_sat  <= 1'b0;
        end
      end else begin
        r_pre <= r_pre + PRE_W'(1);
        r_tc  <= 1'b0;
      end
    end else begin
      // Hold: the count and prescaler are frozen. sat keeps its value.
      r_tc <= 1'b0;
    end
  end

  assign cout = r_cout;
  assign tc   = r_tc;
  assign sat  = r_sat;

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

  localparam int N = 4;
  localparam int P_MAX [N] = '{9, 15, 9, 9};
  localparam int P_SAT [N] = '{0, 1, 0, 1};
  localparam int P_PRE [N] = '{1, 1, 3, 3};

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] cout_v [N];
  logic       tc_v   [N];
  logic       sat_v  [N];

  int n_cmp = 0;
  int n_err = 0;

  int m_cout [N];
  int m_pre  [N];
  bit m_tc   [N];
  bit m_sat  [N];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cout(cout_v[0]), .tc(tc_v[0]), .sat(sat_v[0]));
  updown_mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(1), .PRESCALE(1)) u_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cout(cout_v[1]), .tc(tc_v[1]), .sat(sat_v[1]));
  updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(3)) u_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cout(cout_v[2]), .tc(tc_v[2]), .sat(sat_v[2]));
  updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1), .PRESCALE(3)) u_d (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cout(cout_v[3]), .tc(tc_v[3]), .sat(sat_v[3]));

  // Reference model: applies the clear/load/step/hold rules directly with integer arithmetic.
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cout[i] = 0; m_pre[i] = 0; m_tc[i] = 1'b0; m_sat[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int tgt;
    for (int i = 0; i < N; i++) begin
      m_tc[i] = 1'b0;
      if (clr) begin
        m_cout[i] = 0; m_pre[i] = 0; m_sat[i] = 1'b0;
      end else if (load) begin
        m_cout[i] = (int'(load_val) > P_MAX[i]) ? P_MAX[i] : int'(load_val);
        m_pre[i] = 0; m_sat[i] = 1'b0;
      end else if (en) begin
        if (m_pre[i] == P_PRE[i] - 1) begin
          m_pre[i] = 0;
          tgt = up ? m_cout[i] + 1 : m_cout[i] - 1;
          if (tgt >= 0 && tgt <= P_MAX[i]) begin
            m_cout[i] = tgt; m_sat[i] = 1'b0;
          end else if (P_SAT[i] != 0) begin
            m_sat[i] = 1'b1;
          end else begin
            m_cout[i] = (tgt < 0) ? P_MAX[i] : 0;
            m_tc[i] = 1'b1;
          end
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end
    end
  endtask

  task automatic expect1(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < N; i++) begin
      expect1($sformatf("%s dut%0d cout", tag, i), 32'(cout_v[i]), 32'(m_cout[i]));
      expect1($sformatf("%s dut%0d tc", tag, i), 32'(tc_v[i]), 32'(m_tc[i]));
      expect1($sformatf("%s dut%0d sat", tag, i), 32'(sat_v[i]), 32'(m_sat[i]));
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
  task automatic cyc(bit e, bit u, bit c, bit l, logic [3:0] lv);
    en = e; up = u; clr = c; load = l; load_val = lv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all("model");
  endtask

  task automatic async_reset(string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all(tag);
    expect1({tag, " dut0 cout"}, 32'(cout_v[0]), 32'd0);
    expect1({tag, " dut0 tc"}, 32'(tc_v[0]), 32'd0);
    expect1({tag, " dut1 sat"}, 32'(sat_v[1]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit         en, up, clr, load;
    logic [3:0] lv;
    int         cout;
    bit         tc, sat;
  } vec_t;
  vec_t tbl[$];

  task automatic add(bit e, bit u, bit c, bit l, logic [3:0] lv, int co, bit t, bit s);
    vec_t v;
    v.en = e; v.up = u; v.clr = c; v.load = l; v.lv = lv;
    v.cout = co; v.tc = t; v.sat = s;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table of directed vectors. The expected columns hold the values for dut0 (MAX=9, PRESCALE=1, wrap).
    for (int k = 1; k <= 9; k++) add(1, 1, 0, 0, 4'd0, k, 0, 0);
    add(1, 1, 0, 0, 4'd0, 0, 1, 0);
    add(0, 0, 0, 1, 4'd2, 2, 0, 0);
    add(1, 0, 0, 0, 4'd0, 1, 0, 0);
    add(1, 0, 0, 0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 4'd0, 9, 1, 0);
    add(1, 1, 0, 0, 4'd0, 0, 1, 0);
    add(0, 0, 1, 1, 4'd5, 0, 0, 0);
    add(0, 0, 0, 1, 4'd12, 9, 0, 0);
    add(1, 1, 0, 1, 4'd3, 3, 0, 0);
    add(1, 1, 0, 0, 4'd0, 4, 0, 0);
    add(0, 1, 0, 0, 4'd0, 4, 0, 0);

    reset = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    model_reset();
    #10;
    check_all("reset");
    reset = 1'b1;

    foreach (tbl[k]) begin
      cyc(tbl[k].en, tbl[k].up, tbl[k].clr, tbl[k].load, tbl[k].lv);
      expect1($sformatf("tbl%0d cout", k), 32'(cout_v[0]), 32'(tbl[k].cout));
      expect1($sformatf("tbl%0d tc", k), 32'(tc_v[0]), 32'(tbl[k].tc));
      expect1($sformatf("tbl%0d sat", k), 32'(sat_v[0]), 32'(tbl[k].sat));
    end

    // Prescaler and enable gating on dut2 (PRESCALE=3).
    cyc(0, 1, 1, 0, 4'd0);
    cyc(1, 1, 0, 0, 4'd0); expect1("pre e1", 32'(cout_v[2]), 32'd0);
    cyc(1, 1, 0, 0, 4'd0); expect1("pre e2", 32'(cout_v[2]), 32'd0);
    cyc(1, 1, 0, 0, 4'd0); expect1("pre e3", 32'(cout_v[2]), 32'd1);
    cyc(1, 1, 0, 0, 4'd0); expect1("pre tick", 32'(cout_v[2]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 0, 4'd0); expect1("pre frozen", 32'(cout_v[2]), 32'd1);
    end
    cyc(1, 1, 0, 0, 4'd0); expect1("pre re1", 32'(cout_v[2]), 32'd1);
    cyc(1, 1, 0, 0, 4'd0); expect1("pre re2", 32'(cout_v[2]), 32'd2);

    // Saturation on dut1 (MAX=15, SATURATE=1).
    cyc(0, 1, 0, 1, 4'd14); expect1("sat ld", 32'(cout_v[1]), 32'd14);
    cyc(1, 1, 0, 0, 4'd0);  expect1("sat s1 cout", 32'(cout_v[1]), 32'd15);
    expect1("sat s1 sat", 32'(sat_v[1]), 32'd0);
    cyc(1, 1, 0, 0, 4'd0);  expect1("sat s2 cout", 32'(cout_v[1]), 32'd15);
    expect1("sat s2 sat", 32'(sat_v[1]), 32'd1);
    cyc(1, 1, 0, 0, 4'd0);  expect1("sat s3 sat", 32'(sat_v[1]), 32'd1);
    expect1("sat s3 tc", 32'(tc_v[1]), 32'd0);
    cyc(1, 0, 0, 0, 4'd0);  expect1("sat dn cout", 32'(cout_v[1]), 32'd14);
    expect1("sat dn sat", 32'(sat_v[1]), 32'd0);

    // Async reset while dut0 shows tc and dut1 shows sat, then while dut0 holds 7.
    cyc(0, 1, 0, 1, 4'd15);
    cyc(1, 1, 0, 0, 4'd0);
    expect1("ar pre tc", 32'(tc_v[0]), 32'd1);
    expect1("ar pre sat", 32'(sat_v[1]), 32'd1);
    async_reset("arst1");
    cyc(0, 1, 0, 1, 4'd7);
    expect1("ar pre cout", 32'(cout_v[0]), 32'd7);
    async_reset("arst2");
    cyc(1, 1, 0, 0, 4'd0);
    expect1("ar resume a", 32'(cout_v[0]), 32'd1);
    expect1("ar resume c", 32'(cout_v[2]), 32'd0);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset("arst_rnd");
      end else begin
        cyc($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 29) == 0,
            $urandom_range(0, 14) == 0, 4'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter with a clock-enable prescaler, synchronous clear and load, and selectable wrap or saturate behaviour. It is the general-purpose successor to the fixed 4-bit free-running counter. It serves as a reusable timer and event counter for control logic in this codebase. Outputs are registered. Terminal-count and saturation flags let downstream logic react without decoding `cout`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits; legal range is 2..32.
- `MAX`, default 2**WIDTH-1: top count value. The count range is 0..MAX, and 1 ≤ MAX ≤ 2**WIDTH-1.
- `SATURATE`, default 0: 0 means wrap at the limits; 1 means hold at the limits.
- `PRESCALE`, default 1: number of enabled cycles per count step; legal range is 1..256.

Ports:
- `clk` (in, 1): the single clock; all logic is rising-edge.
- `reset` (in, 1): asynchronous, active-low reset (low = reset asserted).
- `en` (in, 1): count enable; it gates both the prescaler and stepping.
- `up` (in, 1): direction; 1 counts up, 0 counts down. Sampled on the step edge.
- `clr` (in, 1): synchronous clear.
- `load` (in, 1): synchronous load.
- `load_val` (in, WIDTH): value to load.
- `cout` (out, WIDTH): current count.
- `tc` (out, 1): one-cycle pulse on a wrap.
- `sat` (out, 1): high while a step has been blocked at a limit (SATURATE=1 only).

## Operation
- Internal prescaler `pre_cnt` runs over 0..PRESCALE-1 (width is clog2(PRESCALE), minimum 1).
  - While `en`=1, it advances every cycle and wraps to 0.
  - A "step" occurs on an edge where `en`=1 and `pre_cnt`==PRESCALE-1.
  - With PRESCALE=1, every enabled cycle is a step.
- Edge priority: `clr` > `load` > step > hold.
  - `clr`: `cout`←0, `pre_cnt`←0, `tc`←0, `sat`←0.
  - `load`: `cout`←min(`load_val`, MAX), `pre_cnt`←0, `tc`←0, `sat`←0.
  - Step, up, `cout`<MAX: `cout`+1.
  - Step, down, `cout`>0: `cout`-1.
  - Step, up, `cout`==MAX:
    - SATURATE=0: `cout`←0 and `tc`←1.
    - SATURATE=1: `cout` holds and `sat`←1.
  - Step, down, `cout`==0:
    - SATURATE=0: `cout`←MAX and `tc`←1.
    - SATURATE=1: `cout` holds and `sat`←1.
  - Hold (`en`=0, no `clr`/`load`): `cout` and `pre_cnt` are frozen.
- `tc` is 0 on every edge that is not a wrap step. It is therefore exactly one cycle wide per wrap.
- `sat` stays 1 until `cout` changes value through a step, `clr` or `load`. It is constantly 0 when SATURATE=0.
- Arithmetic is unsigned in WIDTH bits; `cout` never leaves 0..MAX.
- Direction may change on any cycle; only the value of `up` on the step edge matters.

## Timing
- Reset values: `cout`=0, `tc`=0, `sat`=0, `pre_cnt`=0.
  - Takes effect immediately on `reset` falling, independent of `clk`.
  - Release is synchronised by the caller; the first possible step is the first rising edge with `reset` high.
- Reset asserted mid-count or mid-prescale clears everything at once. Counting restarts from 0 with a full PRESCALE interval.
- Latency: `cout`, `tc` and `sat` update on the same rising edge that qualifies the step, clear or load. All outputs are registered, with no combinational input-to-output paths.
- Step rate: one step per PRESCALE enabled cycles. The first step after reset, `clr` or `load` comes PRESCALE enabled cycles later.
- `clr` and `load` asserted together: `clr` wins. Either one together with a step edge: the step is discarded and the prescaler restarts.
- `load_val` > MAX is clamped to MAX.

## Test plan
- Reset, count up, wrap (WIDTH=4, MAX=9, PRESCALE=1, SATURATE=0): `reset` low for 10 ns, then `en`=1, `up`=1, 10 ns clock.
  - `cout` goes 0,1,…,9,0.
  - `tc` is high for exactly one cycle, coinciding with `cout`=0 after the 9.
- Count down, wrap and direction change (same config): load 2, then count down.
  - `cout` goes 2,1,0,9 with a `tc` pulse at 9.
  - Setting `up`=1 then gives 0, with a `tc` pulse.
- Saturate (SATURATE=1, MAX=15): load 14, count up for 4 steps.
  - `cout` goes 14,15,15,15; `sat` rises with the first blocked step; `tc` stays 0.
  - Setting `up`=0 gives `cout`=14 and `sat`=0.
- Prescaler and enable gating (PRESCALE=3): with `en`=1, `cout` increments every 3rd edge.
  - Dropping `en` for 5 cycles after one prescale tick freezes `cout` and `pre_cnt`.
  - After re-enable, the next increment comes 2 enabled cycles later.
- Priority and clamp (MAX=9): `clr` and `load` with `load_val`=5 in the same cycle gives `cout`=0.
  - `load` alone with `load_val`=12 gives `cout`=9.
  - `load` on a step edge gives the loaded value, with no increment.
- Async reset mid-operation: assert `reset` low between clock edges with `cout`=7 and `sat`/`tc` active.
  - All outputs read 0 before the next edge.
  - Counting resumes from 0 after release.
